// File: rtl/fixed_prelu_channelwise_pkg.sv
// Shared constants and types for the channel-wise fixed-point PReLU.
package fixed_prelu_channelwise_pkg;

    // Default rounding shift: number of fractional bits in alpha.
    localparam int unsigned DEF_ALPHA_FRAC   = 4;
    // Default saturation width: total bits of each output lane.
    localparam int unsigned DEF_OUT_WIDTH    = 8;
    // Default depth of the per-channel alpha table.
    localparam int unsigned DEF_NUM_CHANNELS = 4;

    // Index width for a table of n entries; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CH_IDX_W = idx_width(DEF_NUM_CHANNELS);

    // Channel index for the default table depth.
    typedef logic [CH_IDX_W-1:0] ch_idx_t;

endpackage

// File: rtl/fixed_prelu_lane.sv
// One PReLU lane: positive inputs pass through, non-positive inputs are
// scaled by alpha with round-half-up, then everything saturates to OUT_W.
module fixed_prelu_lane
    import fixed_prelu_channelwise_pkg::*;
#(
    parameter int unsigned IN_W       = 8,
    parameter int unsigned ALPHA_W    = 8,
    parameter int unsigned ALPHA_FRAC = DEF_ALPHA_FRAC,
    parameter int unsigned OUT_W      = DEF_OUT_WIDTH
) (
    input  logic signed [IN_W-1:0]    x,
    input  logic signed [ALPHA_W-1:0] alpha,
    output logic signed [OUT_W-1:0]   y
);

    localparam int unsigned PROD_W = IN_W + ALPHA_W;
    // One guard bit so the rounding add can never wrap.
    localparam int unsigned SUM_W  = PROD_W + 1;
    localparam int unsigned EXT_W  = (SUM_W > OUT_W) ? SUM_W : OUT_W;

    localparam logic signed [SUM_W-1:0] HALF =
        (ALPHA_FRAC > 0) ? (SUM_W'(1) <<< (ALPHA_FRAC - 1)) : '0;
    localparam logic signed [EXT_W-1:0] MAX_OUT =
        EXT_W'((longint'(1) <<< (OUT_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] MIN_OUT = ~MAX_OUT;

    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  scaled;
    logic signed [EXT_W-1:0]  pre_sat;
    logic                     positive;

    // Full-width multiply, round-half-up shift, select, then saturate.
    always_comb begin
        positive = !x[IN_W-1] && (x != '0);
        prod     = PROD_W'(x) * PROD_W'(alpha);
        scaled   = (SUM_W'(prod) + HALF) >>> ALPHA_FRAC;
        pre_sat  = positive ? EXT_W'(x) : EXT_W'(scaled);
        if (pre_sat > MAX_OUT) begin
            y = MAX_OUT[OUT_W-1:0];
        end else if (pre_sat < MIN_OUT) begin
            y = MIN_OUT[OUT_W-1:0];
        end else begin
            y = pre_sat[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/fixed_prelu_channelwise.sv
// Channel-wise PReLU over PARALLELISM lanes per beat. Each channel spans
// BEATS_PER_CHANNEL beats and owns one writable alpha entry. Two register
// stages with a single global stall: S1 captures data and alpha at
// acceptance, S2 holds the rounded/saturated result.
module fixed_prelu_channelwise
    import fixed_prelu_channelwise_pkg::*;
#(
    parameter int unsigned DATA_IN_0_PRECISION_0  = 8,
    parameter int unsigned DATA_IN_0_PRECISION_1  = 4,
    parameter int unsigned DATA_OUT_0_PRECISION_0 = DEF_OUT_WIDTH,
    parameter int unsigned DATA_OUT_0_PRECISION_1 = 4,
    parameter int unsigned PARALLELISM            = 4,
    parameter int unsigned BEATS_PER_CHANNEL      = 2,
    parameter int unsigned NUM_CHANNELS           = DEF_NUM_CHANNELS,
    parameter int unsigned ALPHA_PRECISION_0      = 8,
    parameter int unsigned ALPHA_PRECISION_1      = DEF_ALPHA_FRAC,
    parameter int          ALPHA_RESET            = 4,
    localparam int unsigned CHW = idx_width(NUM_CHANNELS)
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [PARALLELISM-1:0][DATA_IN_0_PRECISION_0-1:0]   data_in_0,
    input  logic                                                data_in_0_valid,
    output logic                                                data_in_0_ready,
    output logic [PARALLELISM-1:0][DATA_OUT_0_PRECISION_0-1:0]  data_out_0,
    output logic                                                data_out_0_valid,
    input  logic                                                data_out_0_ready,
    input  logic                                                alpha_wr_valid,
    input  logic [CHW-1:0]                                      alpha_wr_addr,
    input  logic [ALPHA_PRECISION_0-1:0]                        alpha_wr_data,
    output logic [CHW-1:0]                                      channel_idx
);

    localparam int unsigned BW = idx_width(BEATS_PER_CHANNEL);
    localparam logic [CHW:0] NCH_LIM  = (CHW + 1)'(NUM_CHANNELS);
    localparam logic [CHW-1:0] CH_LAST = CHW'(NUM_CHANNELS - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS_PER_CHANNEL - 1);

    generate
        if (DATA_IN_0_PRECISION_1 != DATA_OUT_0_PRECISION_1) begin : g_bad_frac
            $error("fixed_prelu_channelwise: input and output fractional widths must match");
        end
        if (NUM_CHANNELS < 1) begin : g_bad_nch
            $error("fixed_prelu_channelwise: NUM_CHANNELS must be at least 1");
        end
    endgenerate

    logic [ALPHA_PRECISION_0-1:0] alpha_tab [NUM_CHANNELS];
    logic [CHW-1:0]               ch_cnt;
    logic [BW-1:0]                beat_cnt;

    logic                                               s1_valid;
    logic [PARALLELISM-1:0][DATA_IN_0_PRECISION_0-1:0]  s1_data;
    logic [ALPHA_PRECISION_0-1:0]                       s1_alpha;
    logic [CHW-1:0]                                     s1_ch;

    logic                                               s2_valid;
    logic [PARALLELISM-1:0][DATA_OUT_0_PRECISION_0-1:0] s2_data;
    logic [CHW-1:0]                                     s2_ch;

    logic [PARALLELISM-1:0][DATA_OUT_0_PRECISION_0-1:0] lane_y;
    logic                                               enable;
    logic                                               accept;

    assign enable           = !s2_valid || data_out_0_ready;
    assign accept           = data_in_0_valid && enable;
    assign data_in_0_ready  = enable;
    assign data_out_0       = s2_data;
    assign data_out_0_valid = s2_valid;
    assign channel_idx      = s2_ch;

    // Alpha table: reset to ALPHA_RESET, out-of-range addresses dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                alpha_tab[i] <= ALPHA_PRECISION_0'(ALPHA_RESET);
            end
        end else if (alpha_wr_valid && ({1'b0, alpha_wr_addr} < NCH_LIM)) begin
            alpha_tab[alpha_wr_addr] <= alpha_wr_data;
        end
    end

    // Beat and channel counters advance on each accepted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
            ch_cnt   <= '0;
        end else if (accept) begin
            if (beat_cnt == BEAT_LAST) begin
                beat_cnt <= '0;
                ch_cnt   <= (ch_cnt == CH_LAST) ? '0 : ch_cnt + 1'b1;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // S1: capture lanes, channel and that channel's alpha at acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_alpha <= '0;
            s1_ch    <= '0;
        end else if (enable) begin
            s1_valid <= accept;
            if (accept) begin
                s1_data  <= data_in_0;
                s1_alpha <= alpha_tab[ch_cnt];
                s1_ch    <= ch_cnt;
            end
        end
    end

    for (genvar g = 0; g < PARALLELISM; g++) begin : g_lane
        fixed_prelu_lane #(
            .IN_W       (DATA_IN_0_PRECISION_0),
            .ALPHA_W    (ALPHA_PRECISION_0),
            .ALPHA_FRAC (ALPHA_PRECISION_1),
            .OUT_W      (DATA_OUT_0_PRECISION_0)
        ) u_lane (
            .x     (s1_data[g]),
            .alpha (s1_alpha),
            .y     (lane_y[g])
        );
    end

    // S2: register rounded/saturated lanes; holds while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_ch    <= '0;
        end else if (enable) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= lane_y;
                s2_ch   <= s1_ch;
            end
        end
    end

endmodule

// File: tb/tb_fixed_prelu_channelwise.sv
// Self-checking bench: directed cases plus randomized traffic against a
// behavioural PReLU model. Two instances: 8-bit output / 4 channels and
// 6-bit output / 3 channels (the latter also drops writes to address 3).
module tb_fixed_prelu_channelwise;
    import fixed_prelu_channelwise_pkg::*;

    localparam int P      = 4;
    localparam int ASCALE = 16;

    typedef struct packed {
        logic [P-1:0][7:0] v;
        ch_idx_t           ch;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [P-1:0][7:0] din;
    logic              din_valid;
    logic              out_ready;
    logic              wr_valid;
    logic [1:0]        wr_addr;
    logic [7:0]        wr_data;

    logic              rdy8, rdy6, v8, v6;
    logic [P-1:0][7:0] q8;
    logic [P-1:0][5:0] q6;
    logic [1:0]        ch8, ch6;

    fixed_prelu_channelwise #(
        .DATA_OUT_0_PRECISION_0 (8),
        .NUM_CHANNELS           (4)
    ) dut8 (
        .clk(clk), .rst(rst),
        .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(rdy8),
        .data_out_0(q8), .data_out_0_valid(v8), .data_out_0_ready(out_ready),
        .alpha_wr_valid(wr_valid), .alpha_wr_addr(wr_addr), .alpha_wr_data(wr_data),
        .channel_idx(ch8)
    );

    fixed_prelu_channelwise #(
        .DATA_OUT_0_PRECISION_0 (6),
        .NUM_CHANNELS           (3)
    ) dut6 (
        .clk(clk), .rst(rst),
        .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(rdy6),
        .data_out_0(q6), .data_out_0_valid(v6), .data_out_0_ready(out_ready),
        .alpha_wr_valid(wr_valid), .alpha_wr_addr(wr_addr), .alpha_wr_data(wr_data),
        .channel_idx(ch6)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int   alpha_m [2][4];
    int   beats_m [2];
    int   nch_m   [2] = '{4, 3};
    int   ow_m    [2] = '{8, 6};
    exp_t q_exp8 [$];
    exp_t q_exp6 [$];
    logic held     [2];
    exp_t held_val [2];

    function automatic int prelu_ref(input int x, input int a, input int ow);
        int p, y, hi, lo;
        if (x > 0) begin
            y = x;
        end else begin
            p = x * a + ASCALE / 2;
            y = p / ASCALE;
            if ((p % ASCALE) != 0 && p < 0) y = y - 1;
        end
        hi = (1 <<< (ow - 1)) - 1;
        lo = -(1 <<< (ow - 1));
        if (y > hi) y = hi;
        if (y < lo) y = lo;
        return y;
    endfunction

    function automatic exp_t make_exp(input int k);
        exp_t e;
        int   c;
        c    = (beats_m[k] / 2) % nch_m[k];
        e.ch = ch_idx_t'(c);
        for (int l = 0; l < P; l++) begin
            e.v[l] = 8'(prelu_ref(int'($signed(din[l])), alpha_m[k][c], ow_m[k]));
        end
        beats_m[k]++;
        return e;
    endfunction

    function automatic exp_t observe(input int k);
        exp_t o;
        if (k == 0) begin
            o.v  = q8;
            o.ch = ch8;
        end else begin
            for (int l = 0; l < P; l++) o.v[l] = {{2{q6[l][5]}}, q6[l]};
            o.ch = ch6;
        end
        return o;
    endfunction

    function automatic logic out_v(input int k);
        return (k == 0) ? v8 : v6;
    endfunction

    function automatic logic in_r(input int k);
        return (k == 0) ? rdy8 : rdy6;
    endfunction

    // Scoreboard: predict acceptances, compare every delivered beat,
    // and require outputs to hold while stalled.
    always @(negedge clk) begin
        exp_t o, e;
        if (!rst) begin
            q_exp8.delete();
            q_exp6.delete();
            for (int k = 0; k < 2; k++) begin
                beats_m[k] = 0;
                held[k]    = 1'b0;
                for (int c = 0; c < 4; c++) alpha_m[k][c] = 4;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                o = observe(k);
                if (held[k]) check((k == 0) ? "hold8" : "hold6", {o, out_v(k)}, {held_val[k], 1'b1});
                if (out_v(k) && out_ready) begin
                    if ((k == 0 ? q_exp8.size() : q_exp6.size()) == 0) begin
                        check("spurious_beat", 1, 0);
                    end else begin
                        e = (k == 0) ? q_exp8.pop_front() : q_exp6.pop_front();
                        check((k == 0) ? "beat8" : "beat6", o, e);
                    end
                end
                held[k]     = out_v(k) && !out_ready;
                held_val[k] = o;
                if (din_valid && in_r(k)) begin
                    if (k == 0) q_exp8.push_back(make_exp(k));
                    else        q_exp6.push_back(make_exp(k));
                end
            end
            if (wr_valid) begin
                for (int k = 0; k < 2; k++) begin
                    if (int'(wr_addr) < nch_m[k]) alpha_m[k][wr_addr] = int'($signed(wr_data));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [P-1:0][7:0] d, input logic do_wr,
                        input logic [1:0] a, input logic [7:0] wd);
        logic acc;
        acc = 1'b0;
        tick();
        din       = d;
        din_valid = 1'b1;
        wr_valid  = do_wr;
        wr_addr   = a;
        wr_data   = wd;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = rdy8;
            tick();
        end
        din_valid = 1'b0;
        wr_valid  = 1'b0;
        check("send_accept", acc, 1);
    endtask

    task automatic wait_out();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (v8) break;
        end
        check("out_timeout", v8, 1);
    endtask

    task automatic write_all(input logic [7:0] wd);
        for (int a = 0; a < 4; a++) begin
            tick();
            wr_valid = 1'b1;
            wr_addr  = 2'(a);
            wr_data  = wd;
        end
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    function automatic logic [7:0] rand_lane();
        case ($urandom_range(0, 3))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    int   ch_seq [16];
    int   got, sent;
    logic acc;

    initial begin
        rst       = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        out_ready = 1'b1;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {v8, v6}, 2'b00);
        check("rst_data", q8, 0);
        check("rst_ch", ch8, 0);
        check("rst_ready", {rdy8, rdy6}, 2'b11);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", rdy8, 1);

        // Defaults, alpha 0.25: latency and rounding
        send(32'h00FFFDF0, 1'b0, 2'd0, 8'd0);
        @(negedge clk);
        check("lat_not_yet", v8, 0);
        @(negedge clk);
        check("lat_valid", v8, 1);
        check("lat_data", q8, 32'h0000FFFC);
        check("lat_ch", ch8, 0);

        // alpha = -1.0: negative inputs flip sign, -128 saturates
        write_all(8'hF0);
        send(32'h10807F05, 1'b0, 2'd0, 8'd0);
        wait_out();
        check("neg_alpha8", q8, 32'h107F7F05);
        check("neg_alpha6", q6, {6'h10, 6'h1F, 6'h1F, 6'h05});

        // alpha = 1.0: narrow output saturates both ways
        write_all(8'h10);
        send(32'hE01F9C64, 1'b0, 2'd0, 8'd0);
        wait_out();
        check("unit_alpha8", q8, 32'hE01F9C64);
        check("unit_alpha6", q6, {6'h20, 6'h1F, 6'h20, 6'h1F});
        check("unit_ch", ch8, 1);

        // Reset with two beats in flight
        tick();
        din       = 32'h01020304;
        din_valid = 1'b1;
        tick();
        tick();
        din_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_valid", {v8, v6}, 2'b00);
        check("midrst_data", q8, 0);
        check("midrst_ready", rdy8, 1);
        tick();
        rst = 1'b1;

        // Table back to 0.25; write on the same cycle as ch1 beat0
        send(32'hF0F0F0F0, 1'b0, 2'd0, 8'd0);
        wait_out();
        check("post_rst_data", q8, 32'hFCFCFCFC);
        check("post_rst_ch", ch8, 0);
        send(32'hF0F0F0F0, 1'b0, 2'd0, 8'd0);
        wait_out();
        send(32'hF0F0F0F0, 1'b1, 2'd1, 8'd8);
        wait_out();
        check("wr_same_cycle", q8, 32'hFCFCFCFC);
        check("wr_same_ch", ch8, 1);
        send(32'hF0F0F0F0, 1'b0, 2'd0, 8'd0);
        wait_out();
        check("wr_next_beat", q8, 32'hF8F8F8F8);
        check("wr_next_ch", ch8, 1);

        // Stall 5 cycles while streaming 16 beats; channel wraps twice
        pulse_reset();
        got  = 0;
        sent = 0;
        fork
            begin
                din       = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
                din_valid = 1'b1;
                for (int i = 0; i < 100 && sent < 16; i++) begin
                    @(negedge clk);
                    acc = rdy8;
                    tick();
                    if (acc) begin
                        sent++;
                        din = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
                    end
                end
                din_valid = 1'b0;
            end
            begin
                repeat (3) tick();
                out_ready = 1'b0;
                repeat (5) tick();
                out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 200 && got < 16; i++) begin
                    @(negedge clk);
                    if (v8 && !out_ready) check("stall_ready", rdy8, 0);
                    if (v8 && out_ready) begin
                        ch_seq[got] = int'(ch8);
                        got++;
                    end
                end
            end
        join
        check("stream_count", got, 16);
        for (int i = 0; i < 16; i++) check("ch_wrap", ch_seq[i], (i / 2) % 4);

        // Randomized traffic, stalls and table writes
        for (int c = 0; c < 600; c++) begin
            tick();
            din_valid = ($urandom_range(0, 3) != 0);
            din       = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
            out_ready = ($urandom_range(0, 3) != 0);
            wr_valid  = ($urandom_range(0, 7) == 0);
            wr_addr   = 2'($urandom_range(0, 3));
            wr_data   = 8'($urandom);
        end
        tick();
        din_valid = 1'b0;
        wr_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        check("drain8", q_exp8.size(), 0);
        check("drain6", q_exp6.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
